// File: rtl/systolic_array.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_array
//  Function : Elastic serpentine pipeline of PEs, valid/ready in, valid/yumi out.
//  Revision : 1.0
// ============================================================================
module systolic_array #(
    parameter int width_p        = 8,
    parameter int array_width_p  = 8,
    parameter int array_height_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               flush_i,
    output logic               ready_o,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               valid_o,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o,
    output logic               busy_o,
    output logic               idle_o,
    output logic [7:0]         onehot_o
);

    localparam int num_macs_p = array_width_p * array_height_p;

    logic [num_macs_p-1:0] w_valid;
    logic [width_p-1:0]    w_data [num_macs_p];
    logic [num_macs_p-1:0] w_adv;
    logic                  w_accept;
    logic [7:0]            r_onehot;

    assign valid_o  = en_i & w_valid[num_macs_p-1];
    assign data_o   = w_data[num_macs_p-1];
    assign busy_o   = |w_valid;
    assign idle_o   = ~busy_o;
    assign onehot_o = r_onehot;

    // Advance chain resolves back-to-front in one cycle, so a full fabric still streams.
    assign w_adv[num_macs_p-1] = valid_o & yumi_i;
    generate
        for (genvar k = 0; k < num_macs_p - 1; k++) begin : g_adv
            assign w_adv[k] = w_valid[k] & (~w_valid[k+1] | w_adv[k+1]);
        end
    endgenerate

    assign ready_o  = reset_i & en_i & ~flush_i & (~w_valid[0] | w_adv[0]);
    assign w_accept = valid_i & ready_o;

    // Stage k sits in row k/array_width_p; odd rows run right-to-left, which is
    // purely a placement matter, so the logical chain is linear in k.
    generate
        for (genvar k = 0; k < num_macs_p; k++) begin : g_stage
            logic               r_v;
            logic [width_p-1:0] r_d;
            logic               w_load;
            logic [width_p-1:0] w_din;

            if (k == 0) begin : g_head
                assign w_load = w_accept;
                assign w_din  = data_i;
            end else begin : g_body
                assign w_load = w_adv[k-1];
                assign w_din  = w_data[k-1];
            end

            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    r_v <= 1'b0;
                    r_d <= '0;
                end else if (en_i) begin
                    if (flush_i) begin
                        r_v <= 1'b0;
                    end else if (w_load) begin
                        r_v <= 1'b1;
                        r_d <= w_din;
                    end else if (w_adv[k]) begin
                        r_v <= 1'b0;
                    end
                end
            end

            assign w_valid[k] = r_v;
            assign w_data[k]  = r_d;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_onehot <= 8'h01;
        end else if (en_i) begin
            if (flush_i) begin
                r_onehot <= 8'h01;
            end else if (w_accept) begin
                r_onehot <= {r_onehot[6:0], r_onehot[7]};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_array
//  Function : Directed + random bench with a FIFO-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_systolic_array;

    localparam int N = 64;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       en_i;
    logic       flush_i;
    logic       ready_o;
    logic       valid_i;
    logic [7:0] data_i;
    logic       valid_o;
    logic       yumi_i;
    logic [7:0] data_o;
    logic       busy_o;
    logic       idle_o;
    logic [7:0] onehot_o;

    systolic_array dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .en_i     (en_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .yumi_i   (yumi_i),
        .data_o   (data_o),
        .busy_o   (busy_o),
        .idle_o   (idle_o),
        .onehot_o (onehot_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_out    = 0;
    bit         auto_yumi = 1'b0;
    logic [7:0] q[$];
    logic [7:0] m_onehot = 8'h01;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
        if (auto_yumi) yumi_i = valid_o;
        #1;
    endtask

    // The fabric is a 64-deep FIFO: occupancy is the queue size.
    task automatic check_state();
        bit exp_ready;
        exp_ready = en_i && !flush_i && ((q.size() < N) || yumi_i);
        chk("busy_o", busy_o, q.size() != 0);
        chk("idle_o", idle_o, q.size() == 0);
        chk("onehot_o", onehot_o, m_onehot);
        chk("ready_o", ready_o, exp_ready);
        if (!en_i || q.size() == 0) chk("valid_o_idle", valid_o, 0);
    endtask

    task automatic tick();
        bit acc, pop;
        acc = valid_i && ready_o;
        pop = valid_o && yumi_i;
        if (en_i && !flush_i && pop) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                chk("data_o", data_o, q[0]);
                void'(q.pop_front());
                n_out++;
            end
        end
        @(posedge clk_i);
        if (en_i) begin
            if (flush_i) begin
                q.delete();
                m_onehot = 8'h01;
            end else if (acc) begin
                q.push_back(data_i);
                m_onehot = {m_onehot[6:0], m_onehot[7]};
            end
        end
        @(negedge clk_i);
    endtask

    task automatic cyc();
        settle();
        check_state();
        tick();
    endtask

    task automatic drain(input string tag);
        valid_i   = 1'b0;
        auto_yumi = 1'b1;
        for (int i = 0; i < 200 && q.size() > 0; i++) cyc();
        chk(tag, q.size(), 0);
    endtask

    initial begin
        int c, acc_cnt, gaps, outs0;
        logic [7:0] e;
        reset_i = 1'b0; en_i = 1'b1; flush_i = 1'b0;
        valid_i = 1'b0; data_i = 8'h00; yumi_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        #1;
        chk("rst_ready", ready_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_onehot", onehot_o, 8'h01);
        @(negedge clk_i);
        reset_i = 1'b1;
        settle();
        chk("idle_ready", ready_o, 1);
        check_state();

        // Single-word latency
        valid_i = 1'b1; data_i = 8'hA5; auto_yumi = 1'b1;
        settle();
        chk("lat_ready", ready_o, 1);
        tick();
        valid_i = 1'b0;
        c = 0;
        for (int i = 0; i < 200; i++) begin
            settle();
            check_state();
            if (valid_o) break;
            tick();
            c++;
        end
        chk("latency", c, N - 1);
        chk("lat_data", data_o, 8'hA5);
        tick();
        settle();
        chk("lat_one_wide", valid_o, 0);
        check_state();
        tick();

        // Random streaming
        outs0 = n_out;
        for (int i = 0; i < 500; i++) begin
            valid_i = ($urandom_range(0, 99) < 80);
            data_i  = 8'($urandom);
            cyc();
        end
        chk("throughput", ((n_out - outs0) * 2) >= 500, 1);
        drain("stream_drain");

        // Backpressure: fill to capacity, then pop the whole fabric back-to-back
        auto_yumi = 1'b0; yumi_i = 1'b0; valid_i = 1'b1; acc_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            data_i = 8'($urandom);
            settle();
            check_state();
            if (ready_o) acc_cnt++;
            tick();
        end
        chk("bp_accepted", acc_cnt, N);
        settle();
        chk("bp_full_ready", ready_o, 0);
        valid_i = 1'b0; auto_yumi = 1'b1;
        settle();
        chk("bp_pop_ready", ready_o, 1);
        gaps = 0;
        for (int i = 0; i < N; i++) begin
            if (i > 0) settle();
            check_state();
            if (!valid_o) gaps++;
            tick();
        end
        chk("bp_gaps", gaps, 0);
        settle();
        chk("bp_empty_valid", valid_o, 0);
        tick();

        // Enable freeze then resume without loss
        outs0 = n_out; valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_i = 8'($urandom);
            cyc();
        end
        en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'($urandom);
            data_i  = 8'($urandom);
            cyc();
        end
        chk("freeze_busy", busy_o, 1);
        en_i = 1'b1;
        drain("freeze_drain");
        chk("freeze_count", n_out - outs0, 20);

        // Flush
        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_i = 8'($urandom);
            cyc();
        end
        flush_i = 1'b1; auto_yumi = 1'b0; yumi_i = 1'b0;
        settle();
        chk("flush_ready", ready_o, 0);
        check_state();
        tick();
        flush_i = 1'b0; valid_i = 1'b0; auto_yumi = 1'b1;
        settle();
        chk("flush_busy", busy_o, 0);
        chk("flush_onehot", onehot_o, 8'h01);
        for (int i = 0; i < 80; i++) cyc();

        // onehot rotation and wrap
        valid_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e = 8'h01 << (i % 8);
            data_i = 8'($urandom);
            settle();
            chk("onehot_seq", onehot_o, e);
            check_state();
            tick();
        end
        settle();
        chk("onehot_wrap", onehot_o, 8'h02);
        drain("wrap_drain");

        // Asynchronous reset mid-stream
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_i = 8'($urandom);
            cyc();
        end
        valid_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_ready", ready_o, 0);
        chk("arst_onehot", onehot_o, 8'h01);
        q.delete();
        m_onehot = 8'h01;
        @(negedge clk_i);
        reset_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
